// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe game sequencer: validates keypad moves, writes the board,
// alternates turns, detects win/draw and enforces a per-turn timeout.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   play_en             1 = game mode, 0 = main/title (aborts a game)
//   key_valid, key_code one-cycle key strobe; 0 = new game, 1..9 = cell
//   board               18-bit board, cell k at [19-2k:18-2k]; 01 X, 10 O
//   turn_o              0 = X to move, 1 = O to move
//   result              00 running, 01 X wins, 10 O wins, 11 draw
//   phase               00 MAIN, 01 PLAY, 10 EVAL, 11 OVER
//   move_count          stones placed
//   move_ack/move_err   one-cycle move accepted / rejected pulses
//   timeout             one-cycle pulse: turn forfeited
module ttt_turn_ctrl #(
    parameter int TICK_DIV     = 25000,
    parameter int TURN_TIMEOUT = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_en,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [17:0] board,
    output logic        turn_o,
    output logic [1:0]  result,
    output logic [1:0]  phase,
    output logic [3:0]  move_count,
    output logic        move_ack,
    output logic        move_err,
    output logic        timeout
);

    localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TNW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        MAIN = 2'b00,
        PLAY = 2'b01,
        EVAL = 2'b10,
        OVER = 2'b11
    } phase_t;

    phase_t           state, state_n;
    logic [17:0]      board_n;
    logic             turn_n;
    logic [1:0]       result_n;
    logic [3:0]       count_n;
    logic             ack_n, err_n, to_n;
    logic [TKW-1:0]   tick_cnt, tick_n;
    logic [TNW-1:0]   turn_cnt, turnc_n;

    logic             tick_wrap;
    logic             turn_expire;
    logic             key_cell;
    logic [1:0]       sel_cell;

    function automatic logic [1:0] cell_at(
        input logic [17:0] b,
        input logic [3:0]  k
    );
        logic [1:0] c;
        c = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            if (k == 4'(i)) c = b[19-2*i -: 2];
        end
        return c;
    endfunction

    function automatic logic has_line(
        input logic [17:0] b,
        input logic [1:0]  p
    );
        logic [8:0] m;
        for (int i = 1; i <= 9; i++) begin
            m[i-1] = (b[19-2*i -: 2] == p);
        end
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
               (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
               (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    assign tick_wrap   = (tick_cnt == TKW'(TICK_DIV - 1));
    assign turn_expire = tick_wrap && (turn_cnt == TNW'(TURN_TIMEOUT - 1));
    assign key_cell    = (key_code >= 4'd1) && (key_code <= 4'd9);
    assign sel_cell    = cell_at(board, key_code);

    always_comb begin
        state_n  = state;
        board_n  = board;
        turn_n   = turn_o;
        result_n = result;
        count_n  = move_count;
        ack_n    = 1'b0;
        err_n    = 1'b0;
        to_n     = 1'b0;
        tick_n   = tick_cnt;
        turnc_n  = turn_cnt;

        if (!play_en) begin
            state_n  = MAIN;
            board_n  = '0;
            turn_n   = 1'b0;
            result_n = 2'b00;
            count_n  = '0;
            tick_n   = '0;
            turnc_n  = '0;
        end else begin
            unique case (state)
                MAIN: begin
                    state_n = PLAY;
                    tick_n  = '0;
                    turnc_n = '0;
                end
                PLAY: begin
                    if (key_valid && key_cell && sel_cell == 2'b00) begin
                        for (int i = 1; i <= 9; i++) begin
                            if (key_code == 4'(i))
                                board_n[19-2*i -: 2] =
                                    turn_o ? 2'b10 : 2'b01;
                        end
                        count_n = move_count + 4'd1;
                        ack_n   = 1'b1;
                        state_n = EVAL;
                        tick_n  = '0;
                        turnc_n = '0;
                    end else begin
                        if (key_valid && key_code != 4'd0) err_n = 1'b1;
                        // A key in the expiry cycle wins; the counters hold
                        // so the forfeit fires on the next key-free cycle.
                        if (turn_expire) begin
                            if (!key_valid) begin
                                to_n    = 1'b1;
                                turn_n  = ~turn_o;
                                tick_n  = '0;
                                turnc_n = '0;
                            end
                        end else if (tick_wrap) begin
                            tick_n  = '0;
                            turnc_n = turn_cnt + TNW'(1);
                        end else begin
                            tick_n = tick_cnt + TKW'(1);
                        end
                    end
                end
                EVAL: begin
                    if (has_line(board, 2'b01)) begin
                        result_n = 2'b01;
                        state_n  = OVER;
                    end else if (has_line(board, 2'b10)) begin
                        result_n = 2'b10;
                        state_n  = OVER;
                    end else if (move_count == 4'd9) begin
                        result_n = 2'b11;
                        state_n  = OVER;
                    end else begin
                        turn_n  = ~turn_o;
                        tick_n  = '0;
                        turnc_n = '0;
                        state_n = PLAY;
                    end
                end
                OVER: begin
                    if (key_valid && key_code == 4'd0) begin
                        board_n  = '0;
                        result_n = 2'b00;
                        turn_n   = 1'b0;
                        count_n  = '0;
                        tick_n   = '0;
                        turnc_n  = '0;
                        state_n  = PLAY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MAIN;
            board      <= '0;
            turn_o     <= 1'b0;
            result     <= 2'b00;
            move_count <= '0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            timeout    <= 1'b0;
            tick_cnt   <= '0;
            turn_cnt   <= '0;
        end else begin
            state      <= state_n;
            board      <= board_n;
            turn_o     <= turn_n;
            result     <= result_n;
            move_count <= count_n;
            move_ack   <= ack_n;
            move_err   <= err_n;
            timeout    <= to_n;
            tick_cnt   <= tick_n;
            turn_cnt   <= turnc_n;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench for ttt_turn_ctrl: directed game scenarios with
// literal expectations plus randomized play against a game-level model.
module tb_ttt_turn_ctrl;

    localparam int TD    = 4;
    localparam int TT    = 3;
    localparam int LIMIT = TD * TT;

    logic        clk = 1'b0;
    logic        rst;
    logic        play_en;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result;
    logic [1:0]  phase;
    logic [3:0]  move_count;
    logic        move_ack;
    logic        move_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    ttt_turn_ctrl #(.TICK_DIV(TD), .TURN_TIMEOUT(TT)) dut (
        .clk        (clk),
        .rst        (rst),
        .play_en    (play_en),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .board      (board),
        .turn_o     (turn_o),
        .result     (result),
        .phase      (phase),
        .move_count (move_count),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Game-level model: cells hold 0 empty / 1 X / 2 O; the turn timer is
    // a single count of PLAY cycles since it was last cleared.
    int m_cells [1:9];
    int m_turn = 0, m_result = 0, m_phase = 0, m_count = 0;
    int m_ack = 0, m_err = 0, m_to = 0, m_elapsed = 0;
    int ln [0:7][0:2];

    initial begin
        ln = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
               '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int k = 1; k <= 9; k++) m_cells[k] = 0;
    end

    function automatic bit m_win(int p);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[ln[l][0]] == p && m_cells[ln[l][1]] == p &&
                m_cells[ln[l][2]] == p) return 1;
        end
        return 0;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) b[19-2*k -: 2] = 2'(m_cells[k]);
        return b;
    endfunction

    task automatic m_clear();
        for (int k = 1; k <= 9; k++) m_cells[k] = 0;
        m_turn = 0; m_result = 0; m_count = 0; m_elapsed = 0;
    endtask

    always @(posedge clk) begin
        int c;
        c = int'(key_code);
        m_ack = 0; m_err = 0; m_to = 0;
        if (rst) begin
            m_clear();
            m_phase = 0;
        end else if (!play_en) begin
            m_clear();
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_elapsed = 0;
        end else if (m_phase == 1) begin
            if (key_valid && c >= 1 && c <= 9 && m_cells[c] == 0) begin
                m_cells[c] = m_turn ? 2 : 1;
                m_count++;
                m_ack = 1;
                m_phase = 2;
                m_elapsed = 0;
            end else begin
                if (key_valid && c != 0) m_err = 1;
                if (m_elapsed + 1 == LIMIT) begin
                    if (!key_valid) begin
                        m_to = 1;
                        m_turn ^= 1;
                        m_elapsed = 0;
                    end
                end else begin
                    m_elapsed++;
                end
            end
        end else if (m_phase == 2) begin
            if (m_win(1)) begin
                m_result = 1; m_phase = 3;
            end else if (m_win(2)) begin
                m_result = 2; m_phase = 3;
            end else if (m_count == 9) begin
                m_result = 3; m_phase = 3;
            end else begin
                m_turn ^= 1; m_elapsed = 0; m_phase = 1;
            end
        end else begin
            if (key_valid && c == 0) begin
                m_clear();
                m_phase = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_board", 32'(board), 32'(m_board()));
            chk("m_turn", 32'(turn_o), 32'(m_turn));
            chk("m_result", 32'(result), 32'(m_result));
            chk("m_phase", 32'(phase), 32'(m_phase));
            chk("m_count", 32'(move_count), 32'(m_count));
            chk("m_ack", 32'(move_ack), 32'(m_ack));
            chk("m_err", 32'(move_err), 32'(m_err));
            chk("m_timeout", 32'(timeout), 32'(m_to));
        end
    end

    logic ack_s, err_s;

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        ack_s = move_ack;
        err_s = move_err;
        @(negedge clk);
    endtask

    task automatic wait_timeout(output int n);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (timeout) break;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; play_en = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_board", 32'(board), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_pulses", 32'({move_ack, move_err, timeout}), 32'h0);
        rst = 1'b0; play_en = 1'b1;

        // X wins on the top row
        press(4'd1); press(4'd4); press(4'd2); press(4'd5); press(4'd3);
        chk("t1_board", 32'(board), 32'(18'b01_01_01_10_10_00_00_00_00));
        chk("t1_result", 32'(result), 32'h1);
        chk("t1_phase", 32'(phase), 32'h3);
        chk("t1_count", 32'(move_count), 32'h5);

        // draw
        press(4'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'd4);
        press(4'd6); press(4'd8); press(4'd7); press(4'd9);
        chk("t2_board", 32'(board), 32'(18'b01_10_01_01_10_10_10_01_01));
        chk("t2_result", 32'(result), 32'h3);
        chk("t2_phase", 32'(phase), 32'h3);

        // turn timeout after TD*TT idle PLAY cycles
        @(negedge clk); key_valid = 1'b1; key_code = 4'd0;
        @(negedge clk); key_valid = 1'b0;
        wait_timeout(n);
        chk("t4_first_cyc", 32'(n), 32'd12);
        chk("t4_turn1", 32'(turn_o), 32'h1);
        chk("t4_board", 32'(board), 32'h0);
        wait_timeout(n);
        chk("t4_second_cyc", 32'(n), 32'd12);
        chk("t4_turn0", 32'(turn_o), 32'h0);

        // occupied cell rejected
        press(4'd5);
        chk("t3_ack", 32'(ack_s), 32'h1);
        press(4'd5);
        chk("t3_err", 32'(err_s), 32'h1);
        chk("t3_cell5", 32'(board[9:8]), 32'h1);
        chk("t3_turn", 32'(turn_o), 32'h1);
        chk("t3_phase", 32'(phase), 32'h1);

        // abort mid-game
        press(4'd1); press(4'd9);
        chk("t5_count3", 32'(move_count), 32'h3);
        @(negedge clk); play_en = 1'b0;
        @(negedge clk); play_en = 1'b1;
        chk("t5_main", 32'(phase), 32'h0);
        chk("t5_board", 32'(board), 32'h0);
        @(negedge clk);
        chk("t5_play", 32'(phase), 32'h1);
        chk("t5_turn_cnt", 32'({turn_o, move_count}), 32'h0);

        // reset during the EVAL of a winning move
        press(4'd1); press(4'd4); press(4'd2); press(4'd5);
        @(negedge clk); key_valid = 1'b1; key_code = 4'd3;
        @(negedge clk); key_valid = 1'b0; rst = 1'b1;
        chk("t6_eval", 32'(phase), 32'h2);
        @(negedge clk); rst = 1'b0;
        chk("t6_rst_all", 32'({board, turn_o, result, phase, move_count,
                               move_ack, move_err, timeout}), 32'h0);
        press(4'd1); press(4'd4); press(4'd2); press(4'd5); press(4'd3);
        chk("t6_win", 32'(result), 32'h1);
        press(4'd0);
        chk("t6_restart", 32'({board, result, phase}), 32'h1);

        // randomized play
        for (int blk = 0; blk < 20; blk++) begin
            int kv_pct;
            kv_pct = (blk % 2 == 0) ? 30 : 6;
            repeat (200) begin
                @(negedge clk);
                rst       = ($urandom_range(0, 299) == 0);
                play_en   = ($urandom_range(0, 99) >= 3);
                key_valid = ($urandom_range(0, 99) < kv_pct);
                if ($urandom_range(0, 3) == 0)
                    key_code = 4'($urandom_range(10, 15));
                else
                    key_code = 4'($urandom_range(0, 9));
            end
        end
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
